// File: rtl/ifmd_window_reader_if.sv
// Bundle between the window reader, the IFMD RAM read port and the MAC-array window consumer.
// master = window reader, slave = RAM read port plus consumer.
interface ifmd_window_reader_if;
    logic        ifmd_read;
    logic [5:0]  ifmd_read_addr;
    logic [7:0]  ifmd_data;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_pix;
    logic [2:0]  win_row;
    logic [2:0]  win_col;

    modport master (
        output ifmd_read, ifmd_read_addr, win_valid, win_pix, win_row, win_col,
        input  ifmd_data, win_ready
    );

    modport slave (
        input  ifmd_read, ifmd_read_addr, win_valid, win_pix, win_row, win_col,
        output ifmd_data, win_ready
    );
endinterface

// File: rtl/ifmd_window_reader.sv
// Walks a row-major IMG_H x IMG_W feature map, fetching each 3x3 stride-1 window tap by tap
// from the IFMD RAM and presenting the assembled window over a valid/ready handshake.
module ifmd_window_reader #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    ifmd_window_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [2:0] ROW_LAST = 3'(IMG_H - 3);
    localparam logic [2:0] COL_LAST = 3'(IMG_W - 3);
    localparam logic [6:0] W7       = 7'(IMG_W);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  k;
    logic [3:0]  k_nxt;
    logic [2:0]  row;
    logic [2:0]  row_nxt;
    logic [2:0]  col;
    logic [2:0]  col_nxt;
    logic        read;
    logic        read_nxt;
    logic [5:0]  addr;
    logic [5:0]  addr_nxt;
    logic        done_nxt;
    logic        valid;
    logic        cap;
    logic [3:0]  cap_tap;
    logic [71:0] pix;

    // Address of tap t of the window whose top-left pixel is (r, c); computed in 7 bits.
    function automatic logic [5:0] tap_addr(input logic [2:0] r, input logic [2:0] c,
                                            input logic [3:0] t);
        logic [3:0] krc;
        logic [6:0] a;
        case (t)
            4'd0:    krc = 4'b00_00;
            4'd1:    krc = 4'b00_01;
            4'd2:    krc = 4'b00_10;
            4'd3:    krc = 4'b01_00;
            4'd4:    krc = 4'b01_01;
            4'd5:    krc = 4'b01_10;
            4'd6:    krc = 4'b10_00;
            4'd7:    krc = 4'b10_01;
            4'd8:    krc = 4'b10_10;
            default: krc = 4'b00_00;
        endcase
        a = ({4'd0, r} + {5'd0, krc[3:2]}) * W7 + {4'd0, c} + {5'd0, krc[1:0]};
        return a[5:0];
    endfunction

    // Next-state, raster position and next read request.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        row_nxt   = row;
        col_nxt   = col;
        read_nxt  = 1'b0;
        addr_nxt  = addr;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    k_nxt     = 4'd0;
                    row_nxt   = 3'd0;
                    col_nxt   = 3'd0;
                    read_nxt  = 1'b1;
                    addr_nxt  = tap_addr(3'd0, 3'd0, 4'd0);
                end else begin
                    state_nxt = IDLE;
                end
            end
            FETCH: begin
                if (k == 4'd8) begin
                    state_nxt = LAST;
                end else begin
                    k_nxt    = k + 4'd1;
                    read_nxt = 1'b1;
                    addr_nxt = tap_addr(row, col, k + 4'd1);
                end
            end
            LAST: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (!bus.win_ready) begin
                    state_nxt = OUT;
                end else if ((row == ROW_LAST) && (col == COL_LAST)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    k_nxt     = 4'd0;
                end else begin
                    // Raster advance: column fastest, wrap to the next row.
                    if (col == COL_LAST) begin
                        col_nxt = 3'd0;
                        row_nxt = row + 3'd1;
                    end else begin
                        col_nxt = col + 3'd1;
                    end
                    state_nxt = FETCH;
                    k_nxt     = 4'd0;
                    read_nxt  = 1'b1;
                    addr_nxt  = tap_addr(row_nxt, col_nxt, 4'd0);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= 4'd0;
            row   <= 3'd0;
            col   <= 3'd0;
            read  <= 1'b0;
            addr  <= 6'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            read  <= read_nxt;
            addr  <= addr_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
            valid <= (state_nxt == OUT);
        end
    end

    // RAM data lags its read by one cycle, so the tap index is delayed to match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap     <= 1'b0;
            cap_tap <= 4'd0;
            pix     <= 72'd0;
        end else begin
            cap     <= read;
            cap_tap <= k;
            if (cap) begin
                pix[{cap_tap, 3'b000} +: 8] <= bus.ifmd_data;
            end
        end
    end

    assign bus.ifmd_read      = read;
    assign bus.ifmd_read_addr = addr;
    assign bus.win_valid      = valid;
    assign bus.win_pix        = pix;
    assign bus.win_row        = row;
    assign bus.win_col        = col;

endmodule

// File: tb/tb_ifmd_window_reader.sv
// Bench for ifmd_window_reader: an 8x8 and a 5x4 instance, each fed by a RAM holding mem[i]=i,
// checked every cycle against a window-list model plus directed literal expectations.
module tb_ifmd_window_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst_n, a_start, a_busy, a_done;
    logic b_rst_n, b_start, b_busy, b_done;

    ifmd_window_reader_if ia ();
    ifmd_window_reader_if ib ();

    ifmd_window_reader #(.IMG_W(8), .IMG_H(8)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .busy(a_busy), .done(a_done), .bus(ia)
    );
    ifmd_window_reader #(.IMG_W(5), .IMG_H(4)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .busy(b_busy), .done(b_done), .bus(ib)
    );

    logic [7:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    end

    // One-cycle-latency RAMs; non-read cycles return a marker value.
    always @(posedge clk) begin
        ia.ifmd_data <= ia.ifmd_read ? mem[ia.ifmd_read_addr] : 8'hEE;
        ib.ifmd_data <= ib.ifmd_read ? mem[ib.ifmd_read_addr] : 8'hEE;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [71:0] pack9(input logic [7:0] t0, t1, t2, t3, t4, t5, t6, t7, t8);
        return {t8, t7, t6, t5, t4, t3, t2, t1, t0};
    endfunction

    // ---------------- window-list model ----------------
    int         mw [2] = '{8, 5};
    int         mh [2] = '{8, 4};
    int         win_idx [2] = '{0, 0};
    int         rd_idx [2] = '{0, 0};
    int         xfer_tot [2] = '{0, 0};
    int         last_xfer_cyc [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    bit         exp_done [2] = '{1'b0, 1'b0};
    logic [71:0] xpix [2][36];
    int         xrow [2][36];
    int         xcol [2][36];
    bit         mon_en = 1'b0;

    function automatic int exp_addr(input int id, input int w, input int t);
        int r, c;
        r = w / (mw[id] - 2);
        c = w % (mw[id] - 2);
        return (r + t / 3) * mw[id] + c + t % 3;
    endfunction

    function automatic logic [71:0] exp_pix(input int id, input int w);
        logic [71:0] p;
        p = 72'd0;
        for (int t = 0; t < 9; t++) p[8*t +: 8] = mem[exp_addr(id, w, t) % 64];
        return p;
    endfunction

    task automatic model_step(input int id, input logic rst_n_i, input logic done_i,
                              input logic rd, input logic [5:0] ad, input logic vld,
                              input logic rdy, input logic [71:0] pix,
                              input logic [2:0] r, input logic [2:0] c);
        int nwin;
        nwin = (mw[id] - 2) * (mh[id] - 2);
        chk("m_done", 72'(done_i), 72'(exp_done[id]));
        if (done_i) done_cnt[id]++;
        exp_done[id] = 1'b0;
        if (rd) begin
            chk("m_rd_in_window", 72'(rd_idx[id] < 9), 72'(1));
            chk("m_addr", 72'(ad), 72'(exp_addr(id, win_idx[id], rd_idx[id])));
            rd_idx[id]++;
        end
        if (vld) begin
            chk("m_rd_count", 72'(rd_idx[id]), 72'(9));
            chk("m_rd_in_out", 72'(rd), 72'(0));
            chk("m_pix", pix, exp_pix(id, win_idx[id]));
            chk("m_row", 72'(r), 72'(win_idx[id] / (mw[id] - 2)));
            chk("m_col", 72'(c), 72'(win_idx[id] % (mw[id] - 2)));
        end
        if (!rst_n_i) begin
            win_idx[id] = 0;
            rd_idx[id]  = 0;
        end else if (vld && rdy) begin
            xpix[id][win_idx[id]] = pix;
            xrow[id][win_idx[id]] = int'(r);
            xcol[id][win_idx[id]] = int'(c);
            xfer_tot[id]++;
            last_xfer_cyc[id] = cyc;
            rd_idx[id] = 0;
            if (win_idx[id] == nwin - 1) begin
                exp_done[id] = 1'b1;
                win_idx[id] = 0;
            end else begin
                win_idx[id]++;
            end
        end
    endtask

    // Compare process: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            model_step(0, a_rst_n, a_done, ia.ifmd_read, ia.ifmd_read_addr, ia.win_valid,
                       ia.win_ready, ia.win_pix, ia.win_row, ia.win_col);
            model_step(1, b_rst_n, b_done, ib.ifmd_read, ib.ifmd_read_addr, ib.win_valid,
                       ib.win_ready, ib.win_pix, ib.win_row, ib.win_col);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    int first_a [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int first_b [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int s;
    int n;
    logic [71:0] held_pix;

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_start = 1'b1; b_start = 1'b1;
        ia.win_ready = 1'b1; ib.win_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_busy_a", 72'(a_busy), 72'(0));
            chk("rst_busy_b", 72'(b_busy), 72'(0));
        end
        chk("rst_done", 72'(a_done), 72'(0));
        chk("rst_read", 72'(ia.ifmd_read), 72'(0));
        chk("rst_addr", 72'(ia.ifmd_read_addr), 72'(0));
        chk("rst_valid", 72'(ia.win_valid), 72'(0));
        chk("rst_pix", ia.win_pix, 72'd0);
        chk("rst_row", 72'(ia.win_row), 72'(0));
        chk("rst_col", 72'(ia.win_col), 72'(0));
        chk("rst_b_valid", 72'(ib.win_valid), 72'(0));
        mon_en = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
        tick();

        // First window of a default frame.
        a_start = 1'b1;
        s = cyc;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("a_first_rd", 72'(ia.ifmd_read), 72'(1));
            chk("a_first_addr", 72'(ia.ifmd_read_addr), 72'(first_a[i]));
            tick();
        end
        chk("a_last_state_rd", 72'(ia.ifmd_read), 72'(0));
        chk("a_last_state_valid", 72'(ia.win_valid), 72'(0));
        tick();
        chk("a_valid_s11", 72'(ia.win_valid), 72'(1));
        chk("a_first_pix", ia.win_pix, pack9(8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18));
        chk("a_first_row", 72'(ia.win_row), 72'(0));
        chk("a_first_col", 72'(ia.win_col), 72'(0));

        // Rest of the frame with win_ready held high.
        n = 0;
        while (!a_done && n < 1000) begin tick(); n++; end
        chk("a_done_seen", 72'(a_done), 72'(1));
        chk("a_busy_at_done", 72'(a_busy), 72'(0));
        chk("a_xfers", 72'(xfer_tot[0]), 72'(36));
        chk("a_frame_len", 72'(last_xfer_cyc[0] - s), 72'(396));
        chk("a_done_after_last", 72'(cyc - last_xfer_cyc[0]), 72'(1));
        chk("a_win7_pix", xpix[0][6], pack9(8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18, 8'd24, 8'd25, 8'd26));
        chk("a_win7_row", 72'(xrow[0][6]), 72'(1));
        chk("a_win7_col", 72'(xcol[0][6]), 72'(0));
        chk("a_last_pix", xpix[0][35], pack9(8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63));

        // Start in the done cycle is accepted.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("a_restart_busy", 72'(a_busy), 72'(1));
        chk("a_restart_rd", 72'(ia.ifmd_read), 72'(1));
        chk("a_restart_addr", 72'(ia.ifmd_read_addr), 72'(0));

        // Backpressure on window 2.
        n = 0;
        while (xfer_tot[0] < 37 && n < 40) begin tick(); n++; end
        ia.win_ready = 1'b0;
        n = 0;
        while (!ia.win_valid && n < 40) begin tick(); n++; end
        chk("bp_valid_seen", 72'(ia.win_valid), 72'(1));
        held_pix = pack9(8'd1, 8'd2, 8'd3, 8'd9, 8'd10, 8'd11, 8'd17, 8'd18, 8'd19);
        repeat (5) begin
            chk("bp_valid", 72'(ia.win_valid), 72'(1));
            chk("bp_rd", 72'(ia.ifmd_read), 72'(0));
            chk("bp_pix", ia.win_pix, held_pix);
            chk("bp_row", 72'(ia.win_row), 72'(0));
            chk("bp_col", 72'(ia.win_col), 72'(1));
            tick();
        end
        ia.win_ready = 1'b1;
        chk("bp_return_valid", 72'(ia.win_valid), 72'(1));
        tick();
        chk("bp_xfer", 72'(xfer_tot[0]), 72'(38));
        chk("bp_next_fetch", 72'(ia.ifmd_read), 72'(1));
        chk("bp_valid_drop", 72'(ia.win_valid), 72'(0));

        // Start while busy is ignored; reset during FETCH of window 4.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        while (xfer_tot[0] < 39 && n < 40) begin tick(); n++; end
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        chk("mid_fetch_rd", 72'(ia.ifmd_read), 72'(1));
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        chk("mid_rst_busy", 72'(a_busy), 72'(0));
        chk("mid_rst_rd", 72'(ia.ifmd_read), 72'(0));
        chk("mid_rst_valid", 72'(ia.win_valid), 72'(0));
        chk("mid_rst_xfers", 72'(xfer_tot[0]), 72'(39));
        repeat (15) begin
            chk("post_rst_done", 72'(a_done), 72'(0));
            chk("post_rst_busy", 72'(a_busy), 72'(0));
            tick();
        end
        chk("a_done_count", 72'(done_cnt[0]), 72'(1));

        // 5x4 instance: full frame.
        b_start = 1'b1;
        s = cyc;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("b_first_rd", 72'(ib.ifmd_read), 72'(1));
            chk("b_first_addr", 72'(ib.ifmd_read_addr), 72'(first_b[i]));
            tick();
        end
        n = 0;
        while (!b_done && n < 200) begin tick(); n++; end
        chk("b_done_seen", 72'(b_done), 72'(1));
        chk("b_xfers", 72'(xfer_tot[1]), 72'(6));
        chk("b_frame_len", 72'(last_xfer_cyc[1] - s), 72'(66));
        chk("b_last_pix", xpix[1][5], pack9(8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19));
        chk("b_last_row", 72'(xrow[1][5]), 72'(1));
        chk("b_last_col", 72'(xcol[1][5]), 72'(2));
        tick();
        tick();
        chk("b_done_count", 72'(done_cnt[1]), 72'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifmd_window_reader.md
# ifmd_window_reader

Read-side sequencer for the input-feature-map RAM: walks an IMG_H×IMG_W feature map stored row-major in the 64×8 IFMD RAM and issues one read per pixel. It assembles each 3×3 convolution window (stride 1, no padding) and hands the window to the MAC array over a valid/ready handshake. It sits between the IFMD RAM read port and the convolution datapath; the loader owns the RAM write port.

## Interface
- IMG_W, 8, feature-map width in pixels; legal range 3..8.
- IMG_H, 8, feature-map height in pixels; legal range 3..8; IMG_W*IMG_H ≤ 64.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to process a frame; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.
- ifmd_read  out  1  read strobe to the IFMD RAM.
- ifmd_read_addr  out  6  RAM read address.
- ifmd_data  in  8  RAM read data; valid the cycle after ifmd_read was high.
- win_valid  out  1  window on win_pix is complete.
- win_ready  in  1  consumer accepts the window this cycle.
- win_pix  out  72  tap (kr,kc) at bits [8*(3*kr+kc)+7 : 8*(3*kr+kc)], kr/kc = 0..2.
- win_row  out  3  top-left row of the presented window, 0..IMG_H-3.
- win_col  out  3  top-left column of the presented window, 0..IMG_W-3.

## Operation
- States: IDLE, FETCH, LAST, OUT.
- IDLE: start=1 → FETCH, row=col=0, tap k=0; otherwise stay.
- FETCH: ifmd_read=1; ifmd_read_addr=(row+kr)*IMG_W+(col+kc), with kr=k/3 and kc=k%3. Compute the address in 7 bits and truncate to 6 (always <64). k increments each cycle. After issuing k=8 → LAST.
- Capture: the tap index is delayed one cycle. In each cycle after a read, ifmd_data is written into the win_pix slot of the delayed tap index.
- LAST: no read. Captures tap 8 → OUT.
- OUT: win_valid=1. win_pix, win_row and win_col are held stable until the transfer.
- Transfer when win_valid & win_ready:
  - If the window was not the last, advance raster order (col fastest; at col=IMG_W-3, wrap col to 0 and row++), reset k=0 → FETCH.
  - If the window was last (row=IMG_H-3, col=IMG_W-3) → IDLE with done=1 for that one cycle.
- Window count per frame: (IMG_H-2)*(IMG_W-2), which is 36 for the defaults.
- start is ignored while busy. A frame is never aborted except by reset.
- ifmd_read is 0 in IDLE, LAST and OUT. ifmd_read_addr holds its last value when not reading.

## Timing
- Reset (rst_n low at an edge) puts the block in IDLE. Reset values:
  - busy=0, done=0, ifmd_read=0, ifmd_read_addr=0, win_valid=0;
  - win_pix=0, win_row=0, win_col=0; internal counters=0.
- Reset applies in any state, including mid-FETCH or during OUT. The pending window is discarded and no done pulse is produced.
- Per-window cycle timing, with start sampled at cycle S:
  - reads issued at S+1..S+9, taps 0..8 in order;
  - data captured at the ends of S+2..S+10;
  - win_valid first high at S+11.
- With win_ready held high:
  - each window occupies 11 cycles (9 FETCH, 1 LAST, 1 OUT);
  - the next FETCH starts the cycle after the transfer;
  - a default frame takes 396 cycles from the first FETCH to the last transfer;
  - done is high in the cycle after the last transfer, and busy is low in that same cycle.
- Backpressure: OUT may last any number of cycles, with no reads issued and outputs frozen.
- A start arriving in the same cycle as done, while the block is in IDLE, is accepted normally.

## Test plan
Every scenario uses a 1-cycle-latency RAM model preloaded with mem[i]=i.
- Reset: hold rst_n low 3 cycles while start=1 → every output is 0 and busy stays 0.
- First window, defaults, win_ready=1, start pulse at S:
  - ifmd_read_addr sequence at S+1..S+9 is 0,1,2,8,9,10,16,17,18;
  - win_valid rises at S+11 with win_pix taps {0,1,2,8,9,10,16,17,18} and win_row=col=0.
- Full frame, defaults:
  - exactly 36 transfers;
  - the 7th window has row=1, col=0, taps {8,9,10,16,17,18,24,25,26};
  - the last window has taps {45,46,47,53,54,55,61,62,63};
  - one done pulse the cycle after the last transfer, then busy=0.
- Backpressure: drop win_ready for 5 cycles during OUT of window 2 → win_pix and win_row/win_col are constant, ifmd_read=0, win_valid stays 1. Transfer happens on the cycle win_ready returns.
- start mid-frame, then rst_n low during the FETCH of window 4:
  - start pulses while busy are ignored (window count unchanged);
  - after the reset edge: IDLE, ifmd_read=0, win_valid=0, and no done pulse.
- IMG_W=5, IMG_H=4:
  - 6 windows;
  - the first window's address sequence is 0,1,2,5,6,7,10,11,12;
  - the last window has taps {7,8,9,12,13,14,17,18,19} at row=1, col=2.
